// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the field packer and the ID-stage decoder.
// Format codes, major opcodes, loader error codes and immediate range limits.
package rv_isa_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_RSV6 = 3'd6,
      FMT_RSV7 = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_RANGE = 2'd1,
      ERR_ALIGN = 2'd2,
      ERR_FMT   = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } load_state_e;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
   localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
   localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
   localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
   localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
   localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

   typedef struct packed {
      fmt_e        fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } instr_fields_t;

   function automatic logic imm_in_range(input logic signed [31:0] v,
                                         input logic signed [31:0] lo,
                                         input logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I packer: field bundle -> 32-bit instruction word plus
// an error code when the immediate does not fit or is misaligned for its format.
module rv_instr_pack
   import rv_isa_pkg::*;
(
   input  instr_fields_t fields,
   output logic [31:0]   word_c,
   output err_code_e     err_c
);

   logic signed [31:0] imm_s;
   logic [31:0]        imm;

   assign imm   = fields.imm;
   assign imm_s = $signed(fields.imm);

   always_comb begin
      word_c = '0;
      err_c  = ERR_NONE;
      case (fields.fmt)
         FMT_R: word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                          fields.rd, fields.opcode};
         FMT_I: begin
            word_c = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
            if (!imm_in_range(imm_s, IMM12_MIN, IMM12_MAX)) err_c = ERR_RANGE;
         end
         FMT_S: begin
            word_c = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                      imm[4:0], fields.opcode};
            if (!imm_in_range(imm_s, IMM12_MIN, IMM12_MAX)) err_c = ERR_RANGE;
         end
         FMT_B: begin
            word_c = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                      imm[4:1], imm[11], fields.opcode};
            // range wins over alignment when both are wrong
            if (!imm_in_range(imm_s, IMMB_MIN, IMMB_MAX)) err_c = ERR_RANGE;
            else if (imm[0])                               err_c = ERR_ALIGN;
         end
         FMT_U: begin
            word_c = {imm[31:12], fields.rd, fields.opcode};
            if (imm[11:0] != 12'd0) err_c = ERR_ALIGN;
         end
         FMT_J: begin
            word_c = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
            if (!imm_in_range(imm_s, IMMJ_MIN, IMMJ_MAX)) err_c = ERR_RANGE;
            else if (imm[0])                               err_c = ERR_ALIGN;
         end
         default: err_c = ERR_FMT;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams packed RV32I instructions into IMEM at consecutive word addresses,
// dropping bundles whose immediates are illegal and recording the first error.
module instr_encode_loader
   import rv_isa_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned ADDR_W     = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [2:0]        in_funct3,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   output logic [31:0]       imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   load_state_e      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             err_q, err_d;
   err_code_e        err_code_q, err_code_d;

   instr_fields_t    fields;
   logic [31:0]      pack_word;
   err_code_e        pack_err;
   logic             xfer;

   assign fields = '{fmt: fmt_e'(in_fmt), opcode: in_opcode, rd: in_rd,
                     funct3: in_funct3, rs1: in_rs1, rs2: in_rs2,
                     funct7: in_funct7, imm: in_imm};

   rv_instr_pack u_pack (
      .fields (fields),
      .word_c (pack_word),
      .err_c  (pack_err)
   );

   assign in_ready = (state_q == ST_LOAD) && !start && (count_q < CNT_W'(IMEM_DEPTH));
   assign xfer     = in_valid && in_ready;

   // next state, counter and write-port staging
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      if (start) begin
         state_d    = ST_LOAD;
         count_d    = '0;
         err_d      = 1'b0;
         err_code_d = ERR_NONE;
      end else if (xfer) begin
         if (pack_err == ERR_NONE) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            wdata_d = pack_word;
            count_d = count_q + CNT_W'(1);
         end else begin
            err_d = 1'b1;
            if (err_code_q == ERR_NONE) err_code_d = pack_err;
         end
         if (in_last || ((pack_err == ERR_NONE) && (count_q == CNT_W'(IMEM_DEPTH - 1))))
            state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign word_count = count_q;
   assign done       = (state_q == ST_DONE);
   assign err        = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected IMEM writes are queued when
// a bundle is offered and popped when the write strobe appears.
module tb_instr_encode_loader;

   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  word_count;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned exp_cnt  = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   instr_encode_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_last    (in_last),
      .in_fmt     (in_fmt),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_funct3  (in_funct3),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_funct7  (in_funct7),
      .in_imm     (in_imm),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .word_count (word_count),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // every write strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            check("we_addr",  imem_addr,  e[63:32]);
            check("we_wdata", imem_wdata, e[31:0]);
         end
      end
   end

   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] f7, input logic [31:0] imm, input logic last,
                       input logic ok, input logic [31:0] exp_word);
      int unsigned n = 0;
      @(negedge clk);
      in_fmt = fmt; in_opcode = op; in_rd = rd; in_funct3 = f3; in_rs1 = rs1;
      in_rs2 = rs2; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) begin
         check("ready_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      if (ok) begin
         sb.push_back({32'(exp_cnt) << 2, exp_word});
         exp_cnt++;
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b1;
      #1 check("ready_during_start", 32'(in_ready), 32'd0);
      @(negedge clk);
      start   = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_fmt = '0; in_opcode = '0; in_rd = '0; in_funct3 = '0;
      in_rs1 = '0; in_rs2 = '0; in_funct7 = '0; in_imm = '0;
      repeat (3) @(negedge clk);
      check("rst_we",    32'(imem_we),    32'd0);
      check("rst_addr",  imem_addr,       32'd0);
      check("rst_count", 32'(word_count), 32'd0);
      check("rst_done",  32'(done),       32'd0);
      check("rst_err",   32'(err),        32'd0);
      check("rst_ready", 32'(in_ready),   32'd0);
      rst = 1'b0;

      // addi x1,x0,5
      do_start();
      send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
      idle();
      #1 check("addi_count", 32'(word_count), 32'd1);

      // sw x2,8(x0) ; beq x0,x0,-4
      do_start();
      send(3'd2, 7'h23, 5'd0, 3'd2, 5'd0, 5'd2, 7'd0, 32'd8, 1'b0, 1'b1, 32'h00202423);
      send(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, -32'sd4, 1'b0, 1'b1, 32'hFE000EE3);
      idle();
      #1 check("sb_count", 32'(word_count), 32'd2);

      // lui x5 ; jal x1,2048 as last
      do_start();
      send(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7);
      send(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b1, 1'b1, 32'h001000EF);
      idle();
      #1;
      check("jal_done",  32'(done),     32'd1);
      check("jal_ready", 32'(in_ready), 32'd0);

      // rejects: range then misaligned; first code sticks
      do_start();
      check("start_clr_done", 32'(done), 32'd0);
      send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b0, 1'b0, 32'd0);
      send(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 1'b0, 1'b0, 32'd0);
      idle();
      #1;
      check("rej_err",   32'(err),        32'd1);
      check("rej_code",  32'(err_code),   32'd1);
      check("rej_count", 32'(word_count), 32'd0);
      // boundary immediates accepted
      send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, -32'sd2048, 1'b0, 1'b1, 32'h80000093);
      send(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4094, 1'b0, 1'b1, 32'h7E000FE3);
      idle();
      #1 check("bnd_count", 32'(word_count), 32'd2);

      // start clears errors; bad fmt, then rejected in_last ends the load
      do_start();
      check("clr_err",  32'(err),      32'd0);
      check("clr_code", 32'(err_code), 32'd0);
      send(3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      send(3'd4, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000010, 1'b1, 1'b0, 32'd0);
      idle();
      #1;
      check("fmt_code",     32'(err_code), 32'd3);
      check("rej_last_done", 32'(done),    32'd1);

      // fill IMEM back-to-back
      do_start();
      for (int k = 0; k < int'(DEPTH); k++)
         send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'(k), 1'b0, 1'b1,
              {12'(k), 5'd0, 3'd0, 5'd1, 7'h13});
      idle();
      #1;
      check("full_done",  32'(done),       32'd1);
      check("full_ready", 32'(in_ready),   32'd0);
      check("full_count", 32'(word_count), 32'(DEPTH));
      do_start();
      #1;
      check("restart_count", 32'(word_count), 32'd0);
      check("restart_ready", 32'(in_ready),   32'd1);

      // start while a write is in flight: write completes, count cleared
      send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7, 1'b0, 1'b1, 32'h00700093);
      do_start();
      #1 check("flight_count", 32'(word_count), 32'd0);

      // async reset mid-stream
      @(negedge clk);
      in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd1; in_imm = 32'd9; in_valid = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_we",    32'(imem_we),    32'd0);
      check("arst_count", 32'(word_count), 32'd0);
      check("arst_ready", 32'(in_ready),   32'd0);
      check("arst_addr",  imem_addr,       32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("post_rst_count", 32'(word_count), 32'd0);
      check("post_rst_done",  32'(done),       32'd0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
